// File: rtl/mdu_seq_ctrl.sv
// EX-stage multiply/divide sequencer: captures operands, drives the divider
// handshake, stalls EX until the 64-bit {hi,lo} result is available.
module mdu_seq_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_TMO = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_other,
    input  logic        op_valid,
    input  logic        op_mul,
    input  logic        op_div,
    input  logic        op_signed,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        dp_start,
    output logic        dp_annul,
    output logic        dp_signed,
    output logic [31:0] dp_opa,
    output logic [31:0] dp_opb,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    input  logic [63:0] mul_result,
    output logic        stallreq,
    output logic        res_valid,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_tmo
);

    localparam int CW = $clog2(DIV_TMO + MUL_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT0 = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] TMO_CNT  = CW'(DIV_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_DIVZ = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          start_q;
    logic          annul_q;
    logic          signed_q;
    logic [31:0]   opa_q;
    logic [31:0]   opb_q;
    logic          res_valid_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          tmo_q;
    logic          req_s;

    assign req_s = op_valid & (op_mul | op_div) & ~flush;

    // A flush must never let a HI/LO write through, so the write enable is gated directly.
    assign stallreq  = ~flush & (((state_q == S_IDLE) & req_s) | (state_q == S_MUL) |
                                 (state_q == S_DIV) | (state_q == S_DIVZ));
    assign res_valid = res_valid_q & ~flush;

    assign dp_start  = start_q;
    assign dp_annul  = annul_q;
    assign dp_signed = signed_q;
    assign dp_opa    = opa_q;
    assign dp_opb    = opb_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign div_tmo   = tmo_q;

    // Sequencer state, counter, latched operands and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            annul_q     <= 1'b0;
            signed_q    <= 1'b0;
            opa_q       <= 32'h0;
            opb_q       <= 32'h0;
            res_valid_q <= 1'b0;
            hi_q        <= 32'h0;
            lo_q        <= 32'h0;
            tmo_q       <= 1'b0;
        end else begin
            annul_q <= 1'b0;
            tmo_q   <= 1'b0;
            if (flush) begin
                state_q     <= S_IDLE;
                cnt_q       <= '0;
                start_q     <= 1'b0;
                annul_q     <= (state_q == S_DIV);
                res_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req_s) begin
                            opa_q    <= opa;
                            opb_q    <= opb;
                            signed_q <= op_signed;
                            if (op_div) begin
                                if (opb == 32'h0) begin
                                    state_q <= S_DIVZ;
                                end else begin
                                    state_q <= S_DIV;
                                    cnt_q   <= '0;
                                    start_q <= 1'b1;
                                end
                            end else begin
                                state_q <= S_MUL;
                                cnt_q   <= MUL_CNT0;
                            end
                        end
                    end
                    S_MUL: begin
                        if (cnt_q == '0) begin
                            hi_q        <= mul_result[63:32];
                            lo_q        <= mul_result[31:0];
                            res_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_DIV: begin
                        if (div_ready) begin
                            hi_q        <= div_result[63:32];
                            lo_q        <= div_result[31:0];
                            res_valid_q <= 1'b1;
                            start_q     <= 1'b0;
                            state_q     <= S_DONE;
                        end else if (cnt_q == TMO_CNT) begin
                            // Watchdog: abort the divider and retire a zero result.
                            hi_q        <= 32'h0;
                            lo_q        <= 32'h0;
                            res_valid_q <= 1'b1;
                            start_q     <= 1'b0;
                            annul_q     <= 1'b1;
                            tmo_q       <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_DIVZ: begin
                        hi_q        <= opa_q;
                        lo_q        <= 32'h0;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                    S_DONE: begin
                        if (!stall_other) begin
                            res_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        start_q     <= 1'b0;
                        res_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed bench for mdu_seq_ctrl: cycle 0 is the cycle a request is first
// presented; registered outputs are checked 1 time unit after each edge.
module tb_mdu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, stall_other, op_valid, op_mul, op_div, op_signed;
    logic [31:0] opa, opb;
    logic        dp_start, dp_annul, dp_signed;
    logic [31:0] dp_opa, dp_opb;
    logic        div_ready;
    logic [63:0] div_result, mul_result;
    logic        stallreq, res_valid, div_tmo;
    logic [31:0] hi_o, lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_seq_ctrl #(.MUL_LAT(2), .DIV_TMO(40)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_other(stall_other),
        .op_valid(op_valid), .op_mul(op_mul), .op_div(op_div), .op_signed(op_signed),
        .opa(opa), .opb(opb),
        .dp_start(dp_start), .dp_annul(dp_annul), .dp_signed(dp_signed),
        .dp_opa(dp_opa), .dp_opb(dp_opb),
        .div_ready(div_ready), .div_result(div_result), .mul_result(mul_result),
        .stallreq(stallreq), .res_valid(res_valid), .hi_o(hi_o), .lo_o(lo_o),
        .div_tmo(div_tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic mul, input logic div, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op_mul = mul; op_div = div; op_signed = sgn; opa = a; opb = b;
        #1;
    endtask

    task automatic retire();
        op_valid = 1'b0; op_mul = 1'b0; op_div = 1'b0; op_signed = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall_other = 1'b0; op_valid = 1'b0; op_mul = 1'b0;
        op_div = 1'b0; op_signed = 1'b0; opa = 32'h0; opb = 32'h0; div_ready = 1'b0;
        div_result = 64'h0; mul_result = 64'h0;
        tick(); tick();

        // Reset state
        chk("rst_res_valid", {63'h0, res_valid}, 64'h0);
        chk("rst_dp_start", {63'h0, dp_start}, 64'h0);
        chk("rst_hilo", {hi_o, lo_o}, 64'h0);
        chk("rst_dp_opa", {32'h0, dp_opa}, 64'h0);
        chk("rst_stallreq", {63'h0, stallreq}, 64'h0);
        rst = 1'b0;
        tick();

        // MULT -3 * 7 = -21
        mul_result = 64'hFFFF_FFFF_FFFF_FFEB;
        present(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
        chk("mul_c0_stall", {63'h0, stallreq}, 64'h1);
        tick();
        chk("mul_c1_stall", {63'h0, stallreq}, 64'h1);
        chk("mul_c1_opa", {32'h0, dp_opa}, 64'hFFFF_FFFD);
        chk("mul_c1_signed", {63'h0, dp_signed}, 64'h1);
        chk("mul_c1_rv", {63'h0, res_valid}, 64'h0);
        tick();
        chk("mul_c2_stall", {63'h0, stallreq}, 64'h1);
        chk("mul_c2_rv", {63'h0, res_valid}, 64'h0);
        tick();
        chk("mul_c3_rv", {63'h0, res_valid}, 64'h1);
        chk("mul_c3_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_c3_stall", {63'h0, stallreq}, 64'h0);
        retire();
        tick();
        chk("mul_c4_rv", {63'h0, res_valid}, 64'h0);

        // DIVU 100 / 7 -> q=14 r=2, ready at cycle 34
        present(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        chk("divu_c0_stall", {63'h0, stallreq}, 64'h1);
        chk("divu_c0_start", {63'h0, dp_start}, 64'h0);
        for (int c = 1; c <= 33; c++) begin
            tick();
            chk("divu_start_held", {63'h0, dp_start}, 64'h1);
        end
        tick();
        div_ready = 1'b1; div_result = {32'd2, 32'd14}; #1;
        chk("divu_c34_start", {63'h0, dp_start}, 64'h1);
        chk("divu_c34_stall", {63'h0, stallreq}, 64'h1);
        tick();
        div_ready = 1'b0; div_result = 64'h0;
        chk("divu_c35_rv", {63'h0, res_valid}, 64'h1);
        chk("divu_c35_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
        chk("divu_c35_stall", {63'h0, stallreq}, 64'h0);
        chk("divu_c35_start", {63'h0, dp_start}, 64'h0);
        retire();
        tick();

        // DIV 5 / 0 -> hi=5 lo=0, no divider start
        present(1'b0, 1'b1, 1'b1, 32'd5, 32'd0);
        chk("divz_c0_stall", {63'h0, stallreq}, 64'h1);
        tick();
        chk("divz_c1_start", {63'h0, dp_start}, 64'h0);
        chk("divz_c1_rv", {63'h0, res_valid}, 64'h0);
        chk("divz_c1_stall", {63'h0, stallreq}, 64'h1);
        tick();
        chk("divz_c2_rv", {63'h0, res_valid}, 64'h1);
        chk("divz_c2_hilo", {hi_o, lo_o}, {32'd5, 32'd0});
        chk("divz_c2_start", {63'h0, dp_start}, 64'h0);
        retire();
        tick();

        // DIV flushed at cycle 10; annul register shows up on cycle 11
        present(1'b0, 1'b1, 1'b1, 32'd50, 32'd3);
        for (int c = 1; c <= 10; c++) tick();
        flush = 1'b1; #1;
        chk("fl_c10_stall", {63'h0, stallreq}, 64'h0);
        chk("fl_c10_rv", {63'h0, res_valid}, 64'h0);
        chk("fl_c10_start", {63'h0, dp_start}, 64'h1);
        tick();
        flush = 1'b0; retire(); #1;
        chk("fl_c11_annul", {63'h0, dp_annul}, 64'h1);
        chk("fl_c11_start", {63'h0, dp_start}, 64'h0);
        chk("fl_c11_rv", {63'h0, res_valid}, 64'h0);
        chk("fl_c11_stall", {63'h0, stallreq}, 64'h0);
        tick();
        chk("fl_c12_annul", {63'h0, dp_annul}, 64'h0);
        chk("fl_c12_rv", {63'h0, res_valid}, 64'h0);

        // MULTU 0xFFFFFFFF * 2 held by stall_other for 3 cycles
        mul_result = 64'h0000_0001_FFFF_FFFE;
        present(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
        tick(); tick(); tick();
        mul_result = 64'hDEAD_BEEF_0BAD_F00D;
        stall_other = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            if (c == 6) begin
                stall_other = 1'b0;
                retire();
            end
            #1;
            chk("hold_rv", {63'h0, res_valid}, 64'h1);
            chk("hold_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
            chk("hold_stall", {63'h0, stallreq}, 64'h0);
            tick();
        end
        chk("hold_c7_rv", {63'h0, res_valid}, 64'h0);
        chk("hold_c7_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);

        // DIV with no ready: watchdog decision at cycle 40, visible cycle 41
        present(1'b0, 1'b1, 1'b1, 32'd9, 32'd2);
        for (int c = 1; c <= 40; c++) tick();
        chk("tmo_c40_start", {63'h0, dp_start}, 64'h1);
        chk("tmo_c40_tmo", {63'h0, div_tmo}, 64'h0);
        chk("tmo_c40_stall", {63'h0, stallreq}, 64'h1);
        tick();
        retire();
        chk("tmo_c41_tmo", {63'h0, div_tmo}, 64'h1);
        chk("tmo_c41_annul", {63'h0, dp_annul}, 64'h1);
        chk("tmo_c41_rv", {63'h0, res_valid}, 64'h1);
        chk("tmo_c41_hilo", {hi_o, lo_o}, 64'h0);
        chk("tmo_c41_start", {63'h0, dp_start}, 64'h0);
        tick();
        chk("tmo_c42_tmo", {63'h0, div_tmo}, 64'h0);
        chk("tmo_c42_annul", {63'h0, dp_annul}, 64'h0);
        chk("tmo_c42_rv", {63'h0, res_valid}, 64'h0);

        // Reset in the middle of a divide
        present(1'b0, 1'b1, 1'b0, 32'd77, 32'd4);
        for (int c = 1; c <= 5; c++) tick();
        chk("rmid_start", {63'h0, dp_start}, 64'h1);
        rst = 1'b1; retire();
        tick();
        chk("rmid_start_off", {63'h0, dp_start}, 64'h0);
        chk("rmid_opa", {32'h0, dp_opa}, 64'h0);
        chk("rmid_stall", {63'h0, stallreq}, 64'h0);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
